// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes and datapath mux selects.
// Used by riscv_multicycle_ctrl and riscv_mc_aludec.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_AUIPC,
        S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;
    localparam logic [2:0] ALU_SLTU  = 3'd6;
    localparam logic [2:0] ALU_SHIFT = 3'd7;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;
    localparam logic [1:0] RES_IMMEXT    = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    function automatic logic [2:0] immSrcOf(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_aludec.sv
// Combinational ALUControl decode from the FSM's ALU request and the instruction function fields.
module riscv_mc_aludec
    import riscv_mc_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_ALUControl
);

    // funct7b5 means SUB only for register-register ops; in addi it is immediate bit 10.
    always_comb begin
        o_ALUControl = ALU_ADD;
        case (i_aluop)
            ALUOP_SUB: o_ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_ALUControl = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_ALUControl = ALU_SLT;
                    3'b011:  o_ALUControl = ALU_SLTU;
                    3'b100:  o_ALUControl = ALU_XOR;
                    3'b110:  o_ALUControl = ALU_OR;
                    3'b111:  o_ALUControl = ALU_AND;
                    default: o_ALUControl = ALU_SHIFT;
                endcase
            end
            default: o_ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM driving a shared-ALU, unified-memory datapath.
// Optional memory wait-state handshake and timeout enabled by defining RV_MEM_HS_EN.
module riscv_multicycle_ctrl
    import riscv_mc_pkg::*;
#(
    parameter int ALUCTL_W = 3,
    parameter int IMMSRC_W = 3,
    parameter int MEM_TO_W = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [6:0]          i_op,
    input  logic [2:0]          i_funct3,
    input  logic                i_funct7b5,
    input  logic                i_Zero,
    input  logic                i_blt,
    input  logic                i_bltu,
    input  logic                i_mem_ready,
    output logic                o_PCWrite,
    output logic                o_AdrSrc,
    output logic                o_MemWrite,
    output logic                o_IRWrite,
    output logic [1:0]          o_ResultSrc,
    output logic [1:0]          o_ALUSrcA,
    output logic [1:0]          o_ALUSrcB,
    output logic                o_RegWrite,
    output logic [IMMSRC_W-1:0] o_ImmSrc,
    output logic [ALUCTL_W-1:0] o_ALUControl,
    output logic                o_illegal,
    output logic                o_mem_timeout
);

    localparam logic [MEM_TO_W-1:0] MEM_TO_LAST = {{(MEM_TO_W-1){1'b1}}, 1'b0};

    state_t              r_state;
    logic                r_illegal;
    logic                r_memTimeout;
    logic [MEM_TO_W-1:0] r_memCnt;
    logic [1:0]          w_aluop;
    logic [2:0]          w_aluCtl;
    logic                w_take;
    logic                w_memWait;

`ifdef RV_MEM_HS_EN
    assign w_memWait = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                       && !i_mem_ready;
`else
    logic w_unused_memReady;
    assign w_unused_memReady = i_mem_ready;
    assign w_memWait = 1'b0;
`endif

    always_comb begin
        case (i_funct3)
            3'b000:  w_take = i_Zero;
            3'b001:  w_take = !i_Zero;
            3'b100:  w_take = i_blt;
            3'b101:  w_take = !i_blt;
            3'b110:  w_take = i_bltu;
            3'b111:  w_take = !i_bltu;
            default: w_take = 1'b0;
        endcase
    end

    // Bad branch funct3 is caught at dispatch so BRANCH never sees an unresolvable compare.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= S_FETCH;
            r_illegal    <= 1'b0;
            r_memTimeout <= 1'b0;
            r_memCnt     <= '0;
        end else if (w_memWait) begin
            if (r_memCnt == MEM_TO_LAST) begin
                r_memTimeout <= 1'b1;
                r_state      <= S_ILLEGAL;
                r_memCnt     <= '0;
            end else begin
                r_memCnt <= r_memCnt + MEM_TO_W'(1);
            end
        end else begin
            r_memCnt <= '0;
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    case (i_op)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_RTYPE:          r_state <= S_EXECR;
                        OP_ITYPE:          r_state <= S_EXECI;
                        OP_JAL:            r_state <= S_JAL;
                        OP_JALR:           r_state <= S_JALR;
                        OP_LUI:            r_state <= S_LUI;
                        OP_AUIPC:          r_state <= S_AUIPC;
                        OP_BRANCH: begin
                            if (i_funct3[2:1] == 2'b01) begin
                                r_state   <= S_ILLEGAL;
                                r_illegal <= 1'b1;
                            end else begin
                                r_state <= S_BRANCH;
                            end
                        end
                        default: begin
                            r_state   <= S_ILLEGAL;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: r_state <= (i_op == OP_LOAD) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  r_state <= S_FETCH;
                S_EXECR:  r_state <= S_ALUWB;
                S_EXECI:  r_state <= S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_JAL:    r_state <= S_ALUWB;
                S_JALR:   r_state <= S_JAL;
                S_LUI:    r_state <= S_FETCH;
                S_AUIPC:  r_state <= S_ALUWB;
                default:  r_state <= S_ILLEGAL;
            endcase
        end
    end

    // JAL loads PC from ALUOut (target from DECODE or JALR) while the ALU forms the link value.
    always_comb begin
        o_PCWrite   = 1'b0;
        o_AdrSrc    = 1'b0;
        o_MemWrite  = 1'b0;
        o_IRWrite   = 1'b0;
        o_RegWrite  = 1'b0;
        o_ResultSrc = RES_ALUOUT;
        o_ALUSrcA   = SRCA_PC;
        o_ALUSrcB   = SRCB_RS2;
        w_aluop     = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                o_IRWrite   = 1'b1;
                o_PCWrite   = 1'b1;
                o_ALUSrcB   = SRCB_FOUR;
                o_ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
            end
            S_MEMADR, S_JALR: begin
                o_ALUSrcA = SRCA_RS1;
                o_ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: o_AdrSrc = 1'b1;
            S_MEMWB: begin
                o_ResultSrc = RES_DATA;
                o_RegWrite  = 1'b1;
            end
            S_MEMWR: begin
                o_AdrSrc   = 1'b1;
                o_MemWrite = 1'b1;
            end
            S_EXECR: begin
                o_ALUSrcA = SRCA_RS1;
                w_aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                o_ALUSrcA = SRCA_RS1;
                o_ALUSrcB = SRCB_IMM;
                w_aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: o_RegWrite = 1'b1;
            S_BRANCH: begin
                o_ALUSrcA = SRCA_RS1;
                w_aluop   = ALUOP_SUB;
                o_PCWrite = w_take;
            end
            S_JAL: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_FOUR;
                o_PCWrite = 1'b1;
            end
            S_LUI: begin
                o_ResultSrc = RES_IMMEXT;
                o_RegWrite  = 1'b1;
            end
            S_AUIPC: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
            end
            default: ;
        endcase
        if (w_memWait) begin
            o_IRWrite = 1'b0;
            o_PCWrite = 1'b0;
        end
        if (!i_reset) begin
            o_PCWrite  = 1'b0;
            o_MemWrite = 1'b0;
            o_IRWrite  = 1'b0;
            o_RegWrite = 1'b0;
        end
    end

    riscv_mc_aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct3     (i_funct3),
        .i_funct7b5   (i_funct7b5),
        .i_op5        (i_op[5]),
        .o_ALUControl (w_aluCtl)
    );

    assign o_ALUControl  = ALUCTL_W'(w_aluCtl);
    assign o_ImmSrc      = IMMSRC_W'(immSrcOf(i_op));
    assign o_illegal     = r_illegal;
    assign o_mem_timeout = r_memTimeout;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed self-checking bench for riscv_multicycle_ctrl; the handshake section runs only with RV_MEM_HS_EN.
module tb_riscv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       blt;
    logic       bltu;
    logic       memReady;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal, memTimeout;
    logic [1:0] resultSrc, aluSrcA, aluSrcB;
    logic [2:0] immSrc, aluControl;

    int vectorsApplied = 0;
    int miscompares    = 0;

    // Control vector: PCWrite AdrSrc MemWrite IRWrite | ResultSrc | ALUSrcA | ALUSrcB | RegWrite | ALUControl
    localparam logic [13:0] V_FETCH      = 14'b1001_10_00_10_0_000;
    localparam logic [13:0] V_FETCH_HOLD = 14'b0000_10_00_10_0_000;
    localparam logic [13:0] V_DECODE     = 14'b0000_00_01_01_0_000;
    localparam logic [13:0] V_MEMADR     = 14'b0000_00_10_01_0_000;
    localparam logic [13:0] V_MEMRD      = 14'b0100_00_00_00_0_000;
    localparam logic [13:0] V_MEMWB      = 14'b0000_01_00_00_1_000;
    localparam logic [13:0] V_MEMWR      = 14'b0110_00_00_00_0_000;
    localparam logic [13:0] V_EXECR_SUB  = 14'b0000_00_10_00_0_001;
    localparam logic [13:0] V_EXECI_ADD  = 14'b0000_00_10_01_0_000;
    localparam logic [13:0] V_ALUWB      = 14'b0000_00_00_00_1_000;
    localparam logic [13:0] V_BR_TAKE    = 14'b1000_00_10_00_0_001;
    localparam logic [13:0] V_BR_NOT     = 14'b0000_00_10_00_0_001;
    localparam logic [13:0] V_JAL        = 14'b1000_00_01_10_0_000;
    localparam logic [13:0] V_LUI        = 14'b0000_11_00_00_1_000;
    localparam logic [13:0] V_IDLE       = 14'b0000_00_00_00_0_000;

    riscv_multicycle_ctrl #(
        .ALUCTL_W (3),
        .IMMSRC_W (3),
        .MEM_TO_W (4)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_op          (op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_Zero        (zero),
        .i_blt         (blt),
        .i_bltu        (bltu),
        .i_mem_ready   (memReady),
        .o_PCWrite     (pcWrite),
        .o_AdrSrc      (adrSrc),
        .o_MemWrite    (memWrite),
        .o_IRWrite     (irWrite),
        .o_ResultSrc   (resultSrc),
        .o_ALUSrcA     (aluSrcA),
        .o_ALUSrcB     (aluSrcB),
        .o_RegWrite    (regWrite),
        .o_ImmSrc      (immSrc),
        .o_ALUControl  (aluControl),
        .o_illegal     (illegal),
        .o_mem_timeout (memTimeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic lt, input logic ltu);
        op = o; funct3 = f3; funct7b5 = f7; zero = z; blt = lt; bltu = ltu;
    endtask

    task automatic checkOutput(input string tag, input logic [13:0] expVec,
                               input logic expIll, input logic expTo);
        logic [15:0] obs;
        logic [15:0] exp;
        obs = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, regWrite,
               aluControl, illegal, memTimeout};
        exp = {expVec, expIll, expTo};
        vectorsApplied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed ctrl/ill/to=%b required %b", tag, obs, exp);
        end
    endtask

    task automatic checkImm(input string tag, input logic [2:0] expImm);
        vectorsApplied++;
        assert (immSrc === expImm) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed ImmSrc=%0d required %0d", tag, immSrc, expImm);
        end
    endtask

    // Check the current cycle, then advance to 1 time unit after the next rising edge.
    task automatic step(input string tag, input logic [13:0] expVec, input logic expIll);
        #1;
        checkOutput(tag, expVec, expIll, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        memReady = 1'b1;
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_strobes", V_FETCH_HOLD, 1'b0, 1'b0);
        reset = 1'b1;

        step("lw_fetch", V_FETCH, 1'b0);
        checkImm("lw_imm", 3'd0);
        step("lw_decode", V_DECODE, 1'b0);
        step("lw_memadr", V_MEMADR, 1'b0);
        step("lw_memrd", V_MEMRD, 1'b0);
        step("lw_memwb", V_MEMWB, 1'b0);

        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sw_fetch", V_FETCH, 1'b0);
        checkImm("sw_imm", 3'd1);
        step("sw_decode", V_DECODE, 1'b0);
        step("sw_memadr", V_MEMADR, 1'b0);
        step("sw_memwr", V_MEMWR, 1'b0);

        applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        step("bne_nz_fetch", V_FETCH, 1'b0);
        checkImm("b_imm", 3'd2);
        step("bne_nz_decode", V_DECODE, 1'b0);
        step("bne_nz_branch", V_BR_TAKE, 1'b0);

        applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        step("bne_z_fetch", V_FETCH, 1'b0);
        step("bne_z_decode", V_DECODE, 1'b0);
        step("bne_z_branch", V_BR_NOT, 1'b0);

        applyStimulus(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0);
        step("bge_fetch", V_FETCH, 1'b0);
        step("bge_decode", V_DECODE, 1'b0);
        step("bge_lt_branch", V_BR_NOT, 1'b0);

        applyStimulus(7'b1100011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1);
        step("bltu_fetch", V_FETCH, 1'b0);
        step("bltu_decode", V_DECODE, 1'b0);
        step("bltu_branch", V_BR_TAKE, 1'b0);

        applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        step("sub_fetch", V_FETCH, 1'b0);
        step("sub_decode", V_DECODE, 1'b0);
        step("sub_execr", V_EXECR_SUB, 1'b0);
        step("sub_aluwb", V_ALUWB, 1'b0);

        applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        step("addi_fetch", V_FETCH, 1'b0);
        step("addi_decode", V_DECODE, 1'b0);
        step("addi_execi", V_EXECI_ADD, 1'b0);
        step("addi_aluwb", V_ALUWB, 1'b0);

        applyStimulus(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lui_fetch", V_FETCH, 1'b0);
        checkImm("lui_imm", 3'd4);
        step("lui_decode", V_DECODE, 1'b0);
        step("lui_write", V_LUI, 1'b0);

        applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("jal_fetch", V_FETCH, 1'b0);
        checkImm("jal_imm", 3'd3);
        step("jal_decode", V_DECODE, 1'b0);
        step("jal_jump", V_JAL, 1'b0);
        step("jal_link", V_ALUWB, 1'b0);

        applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ill_fetch", V_FETCH, 1'b0);
        step("ill_decode", V_DECODE, 1'b0);
        for (int k = 0; k < 3; k++) step("ill_stuck", V_IDLE, 1'b1);
        reset = 1'b0;
        step("ill_reset_pre", V_IDLE, 1'b1);
        step("ill_reset_post", V_FETCH_HOLD, 1'b0);
        reset = 1'b1;

        applyStimulus(7'b1100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        step("badbr_fetch", V_FETCH, 1'b0);
        step("badbr_decode", V_DECODE, 1'b0);
        step("badbr_illegal", V_IDLE, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("badbr_recover", V_FETCH, 1'b0);
        step("badbr_recover_dec", V_DECODE, 1'b1 ^ 1'b1);

`ifdef RV_MEM_HS_EN
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        step("hs_sw_fetch", V_FETCH, 1'b0);
        step("hs_sw_decode", V_DECODE, 1'b0);
        step("hs_sw_memadr", V_MEMADR, 1'b0);
        memReady = 1'b0;
        for (int k = 0; k < 3; k++) step("hs_sw_wait", V_MEMWR, 1'b0);
        memReady = 1'b1;
        step("hs_sw_ready", V_MEMWR, 1'b0);
        memReady = 1'b0;
        for (int k = 0; k < 15; k++) step("hs_fetch_wait", V_FETCH_HOLD, 1'b0);
        #1;
        checkOutput("hs_timeout", V_IDLE, 1'b0, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hs_timeout_clear", V_FETCH_HOLD, 1'b0, 1'b0);
        reset = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
